// File: rtl/necpu_pkg.sv
// Shared definitions for the NECPU fetch path: default widths, the fetch
// FSM state encoding and the {pc, inst} entry handed to decode.
package necpu_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer between instruction fetch and decode.
// The head register drives decode directly, so its contents stay put while
// the consumer stalls and after the buffer drains or is flushed.
module fetch_skid_buf #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [1:0]        o_count,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic              r_head_vld;
  logic              r_tail_vld;
  logic              w_pop;

  // A pop only means something when the head actually holds an entry.
  assign w_pop = i_pop & r_head_vld;

  // Slot management: head refills from tail first, then from the incoming word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data slots are reset too because the head is visible on
      // the output port and must read as zero straight out of reset.
      r_head     <= '0;
      r_tail     <= '0;
      r_head_vld <= 1'b0;
      r_tail_vld <= 1'b0;
    end else if (i_flush) begin
      // Data is kept so the outputs hold their last value; only validity drops.
      r_head_vld <= 1'b0;
      r_tail_vld <= 1'b0;
    end else if (!r_head_vld || w_pop) begin
      // NOTE: non-blocking assignments let head take the old tail value while
      // tail captures the new word in the same edge.
      if (r_tail_vld) begin
        r_head     <= r_tail;
        r_head_vld <= 1'b1;
        if (i_push) begin
          r_tail <= i_data;
        end else begin
          r_tail_vld <= 1'b0;
        end
      end else if (i_push) begin
        r_head     <= i_data;
        r_head_vld <= 1'b1;
      end else begin
        r_head_vld <= 1'b0;
      end
    end else if (i_push) begin
      r_tail     <= i_data;
      r_tail_vld <= 1'b1;
    end
  end

  assign o_count = {1'b0, r_head_vld} + {1'b0, r_tail_vld};
  assign o_valid = r_head_vld;
  assign o_head  = r_head;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch-side initiator for NECPU instruction memory: owns the PC and the
// IDLE/RUN/HALT control, reads instMem combinationally at the PC and queues
// {pc, inst} pairs for decode. A redirect flushes the queue and reloads the PC.
module inst_fetch_unit #(
  parameter int                ADDR_W   = necpu_pkg::ADDR_W,
  parameter int                INST_W   = necpu_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy
);

  import necpu_pkg::*;

  localparam int ENTRY_W = ADDR_W + INST_W;

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [1:0]         w_count;
  logic               w_buf_valid;
  logic [ENTRY_W-1:0] w_head;
  logic               w_can_accept;
  logic               w_push;

  // A full buffer can still take a word when decode drains one this cycle.
  assign w_can_accept = (w_count != 2'd2) | (w_buf_valid & out_ready);
  // A redirect cycle never pushes: the word at the old PC is on the wrong path.
  assign w_push       = (r_state == ST_RUN) & ~redirect_valid & w_can_accept;

  // Run control: halt_req beats start; a redirect outside RUN leaves the state alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (!redirect_valid && start && !halt_req) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            r_state <= ST_HALT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Program counter: redirect load has priority over the sequential step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  fetch_skid_buf #(
    .DATA_W (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (out_ready),
    .i_flush (redirect_valid),
    .i_data  ({r_pc, imem_inst}),
    .o_count (w_count),
    .o_valid (w_buf_valid),
    .o_head  (w_head)
  );

  assign imem_addr = r_pc;
  assign out_valid = w_buf_valid;
  assign out_pc    = w_head[ENTRY_W-1 -: ADDR_W];
  assign out_inst  = w_head[INST_W-1:0];
  assign busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a queue-level model of the fetch
// stream compared every cycle, plus directed scenarios with literal expectations.
module tb_inst_fetch_unit;
  import necpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h10005555;
      32'd1:   return 32'h0c00aaaa;
      32'd2:   return 32'h10800000;
      32'd3:   return 32'h0c800010;
      32'd4:   return 32'h10a08000;
      32'd5:   return 32'h0ca00000;
      32'd6:   return 32'h38202000;
      32'd7:   return 32'h08250000;
      default: return 32'h0;
    endcase
  endfunction

  assign imem_inst = img(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of fetched entries, a PC and a running flag.
  fetch_entry_t m_q[$];
  logic [31:0]  m_pc;
  logic         m_run;
  fetch_entry_t m_shown;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pc    = 32'h0;
      m_run   = 1'b0;
      m_shown = '0;
    end else begin
      fetch_entry_t e;
      bit take;
      take = (m_q.size() != 0) && out_ready;
      if (redirect_valid) begin
        m_q.delete();
        m_pc = redirect_pc;
        if (halt_req) m_run = 1'b0;
      end else begin
        if (take) void'(m_q.pop_front());
        if (m_run && m_q.size() < 2) begin
          e.pc   = m_pc;
          e.inst = img(m_pc);
          m_q.push_back(e);
          m_pc = m_pc + 32'd1;
        end
        if (halt_req) m_run = 1'b0;
        else if (start) m_run = 1'b1;
      end
      if (m_q.size() != 0) m_shown = m_q[0];
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("model out_valid", {63'd0, out_valid}, {63'd0, m_q.size() != 0});
    check("model busy", {63'd0, busy}, {63'd0, m_run});
    check("model imem_addr", {32'd0, imem_addr}, {32'd0, m_pc});
    check("model out_pc", {32'd0, out_pc}, {32'd0, m_shown.pc});
    check("model out_inst", {32'd0, out_inst}, {32'd0, m_shown.inst});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc, input logic [31:0] inst);
    check({name, " valid"}, {63'd0, out_valid}, 64'd1);
    check({name, " pc"}, {32'd0, out_pc}, {32'd0, pc});
    check({name, " inst"}, {32'd0, out_inst}, {32'd0, inst});
  endtask

  logic [31:0] exp1 [0:8] = '{32'h10005555, 32'h0c00aaaa, 32'h10800000, 32'h0c800010,
                              32'h10a08000, 32'h0ca00000, 32'h38202000, 32'h08250000,
                              32'h00000000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: reset values, then streaming fetch with decode always ready
    do_reset();
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset out_inst", {32'd0, out_inst}, 64'd0);
    check("reset out_pc", {32'd0, out_pc}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    out_ready = 1'b1;
    pulse_start();
    check("t1 busy after start", {63'd0, busy}, 64'd1);
    check("t1 no valid at E0", {63'd0, out_valid}, 64'd0);
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_out("t1 stream", k, exp1[k]);
    end

    // 2: back-pressure holds the head and stops the PC at 2
    do_reset();
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_out("t2 hold", 32'd0, 32'h10005555);
      if (k >= 1) check("t2 pc frozen", {32'd0, imem_addr}, 64'd2);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      expect_out("t2 release", k, exp1[k]);
    end

    // 3: redirect flushes the in-flight entries, one bubble, then target
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'd6;
    tick();
    redirect_valid = 1'b0;
    check("t3 bubble", {63'd0, out_valid}, 64'd0);
    check("t3 pc loaded", {32'd0, imem_addr}, 64'd6);
    tick();
    expect_out("t3 target", 32'd6, 32'h38202000);
    tick();
    expect_out("t3 next", 32'd7, 32'h08250000);

    // 4: halt with two entries buffered; drain, then resume at pc3
    do_reset();
    pulse_start();
    tick();
    tick();
    check("t4 full pc", {32'd0, imem_addr}, 64'd2);
    out_ready = 1'b1;
    halt_req = 1'b1;
    tick();
    out_ready = 1'b0;
    halt_req = 1'b0;
    check("t4 halted", {63'd0, busy}, 64'd0);
    expect_out("t4 head", 32'd1, 32'h0c00aaaa);
    tick();
    tick();
    check("t4 pc frozen", {32'd0, imem_addr}, 64'd3);
    expect_out("t4 still head", 32'd1, 32'h0c00aaaa);
    out_ready = 1'b1;
    tick();
    expect_out("t4 drain", 32'd2, 32'h10800000);
    tick();
    check("t4 empty", {63'd0, out_valid}, 64'd0);
    check("t4 hold pc", {32'd0, out_pc}, 64'd2);
    check("t4 hold inst", {32'd0, out_inst}, 64'h10800000);
    pulse_start();
    check("t4 resumed", {63'd0, busy}, 64'd1);
    tick();
    expect_out("t4 resume", 32'd3, 32'h0c800010);

    // 5: PC wraps from all-ones to zero
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFFFFFF;
    tick();
    redirect_valid = 1'b0;
    check("t5 bubble", {63'd0, out_valid}, 64'd0);
    check("t5 pc loaded", {32'd0, imem_addr}, 64'hFFFFFFFF);
    tick();
    expect_out("t5 top", 32'hFFFFFFFF, 32'h0);
    tick();
    expect_out("t5 wrap", 32'd0, 32'h10005555);

    // 5b: redirect while idle only moves the PC
    do_reset();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd5;
    tick();
    redirect_valid = 1'b0;
    check("t5b pc", {32'd0, imem_addr}, 64'd5);
    check("t5b idle", {63'd0, busy}, 64'd0);
    pulse_start();
    tick();
    expect_out("t5b first", 32'd5, 32'h0ca00000);

    // 6: asynchronous reset with the buffer full
    do_reset();
    pulse_start();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("t6 valid", {63'd0, out_valid}, 64'd0);
    check("t6 inst", {32'd0, out_inst}, 64'd0);
    check("t6 pc", {32'd0, out_pc}, 64'd0);
    check("t6 busy", {63'd0, busy}, 64'd0);
    check("t6 addr", {32'd0, imem_addr}, 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    pulse_start();
    tick();
    expect_out("t6 refetch", 32'd0, 32'h10005555);

    // 7: start and halt_req together from IDLE
    do_reset();
    out_ready = 1'b1;
    start = 1'b1;
    halt_req = 1'b1;
    tick();
    start = 1'b0;
    halt_req = 1'b0;
    tick();
    tick();
    check("t7 idle", {63'd0, busy}, 64'd0);
    check("t7 no fetch", {63'd0, out_valid}, 64'd0);
    check("t7 pc", {32'd0, imem_addr}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
